// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, default geometry and address field helpers
package dcache_pkg;
  typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_WAIT, WR_REQ, WR_DONE} dcache_state_t;
  localparam int DC_SETS = 16;
  localparam int DC_WORDS = 4;
  localparam int OFF_W = 2;
  localparam int DEF_WSEL_W = $clog2(DC_WORDS);
  localparam int DEF_IDX_W = $clog2(DC_SETS);
  localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_WSEL_W - OFF_W;
  function automatic logic [31:0] addr_field(input logic [31:0] a, input int lsb, input int w);
    return (a >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic logic [31:0] line_base(input logic [31:0] a, input int wsel_w);
    return a & ~((32'd1 << (wsel_w + OFF_W)) - 32'd1);
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/data storage with combinational read, byte-enabled word writes
// and valid bits cleared by reset
module dcache_array #(
  parameter int SETS = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [$clog2(SETS)-1:0]  i_rd_idx,
  input  logic [$clog2(WORDS)-1:0] i_rd_wsel,
  output logic                     o_rd_valid,
  output logic [TAG_W-1:0]         o_rd_tag,
  output logic [DATA_W-1:0]        o_rd_word,
  input  logic                     i_wr_en,
  input  logic [$clog2(SETS)-1:0]  i_wr_idx,
  input  logic [$clog2(WORDS)-1:0] i_wr_wsel,
  input  logic [DATA_W/8-1:0]      i_wr_be,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_tag_we,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic                     i_inv
);
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag [SETS];
  logic [DATA_W-1:0] r_data [SETS][WORDS];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_word = r_data[i_rd_idx][i_rd_wsel];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_valid <= '0;
    else if (i_tag_we) r_valid[i_wr_idx] <= 1'b1;
    else if (i_inv) r_valid[i_wr_idx] <= 1'b0;
  end
  always_ff @(posedge i_clk) begin
    if (i_wr_en)
      for (int b = 0; b < DATA_W / 8; b++)
        if (i_wr_be[b]) r_data[i_wr_idx][i_wr_wsel][8*b +: 8] <= i_wr_data[8*b +: 8];
    if (i_tag_we) r_tag[i_wr_idx] <= i_tag;
  end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache for the
// memory stage; load hits return same-cycle, misses and stores stall
module dcache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS = DC_SETS,
  parameter int WORDS_PER_LINE = DC_WORDS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [3:0]            i_req_be,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_stall,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_write,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
  output logic [3:0]            o_mem_req_be,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - WSEL_W - OFF_W;
  dcache_state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_rd_word;
  logic [3:0] r_be;
  logic [WSEL_W-1:0] r_beat, w_wsel, w_r_wsel;
  logic [IDX_W-1:0] w_idx, w_r_idx;
  logic [TAG_W-1:0] w_tag, w_r_tag, w_rd_tag;
  logic w_rd_valid, w_hit, w_lookup, w_capture, w_refill_we, w_store_we, w_beat_last;
  assign w_wsel = WSEL_W'(addr_field(i_req_addr, OFF_W, WSEL_W));
  assign w_idx = IDX_W'(addr_field(i_req_addr, OFF_W + WSEL_W, IDX_W));
  assign w_tag = TAG_W'(addr_field(i_req_addr, OFF_W + WSEL_W + IDX_W, TAG_W));
  assign w_r_wsel = WSEL_W'(addr_field(r_addr, OFF_W, WSEL_W));
  assign w_r_idx = IDX_W'(addr_field(r_addr, OFF_W + WSEL_W, IDX_W));
  assign w_r_tag = TAG_W'(addr_field(r_addr, OFF_W + WSEL_W + IDX_W, TAG_W));
  assign w_hit = w_rd_valid && (w_rd_tag == w_tag);
  assign w_lookup = (r_state == IDLE) && i_req_valid;
  assign w_capture = w_lookup && (i_req_write || !w_hit);
  assign w_store_we = w_lookup && i_req_write && w_hit;
  assign w_refill_we = (r_state == REFILL_WAIT) && i_mem_rvalid;
  assign w_beat_last = r_beat == WSEL_W'(WORDS_PER_LINE - 1);
  dcache_array #(.SETS(SETS), .WORDS(WORDS_PER_LINE), .TAG_W(TAG_W), .DATA_W(DATA_WIDTH)) u_array (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_rd_idx(w_idx),
    .i_rd_wsel(w_wsel),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag(w_rd_tag),
    .o_rd_word(w_rd_word),
    .i_wr_en(w_refill_we || w_store_we),
    .i_wr_idx(w_refill_we ? w_r_idx : w_idx),
    .i_wr_wsel(w_refill_we ? r_beat : w_wsel),
    .i_wr_be(w_refill_we ? 4'hF : i_req_be),
    .i_wr_data(w_refill_we ? i_mem_rdata : i_req_wdata),
    .i_tag_we(w_refill_we && w_beat_last),
    .i_tag(w_r_tag),
    .i_inv((r_state == REFILL_REQ) && i_mem_req_ready)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (w_capture) w_next = i_req_write ? WR_REQ : REFILL_REQ;
      REFILL_REQ:  if (i_mem_req_ready) w_next = REFILL_WAIT;
      REFILL_WAIT: if (i_mem_rvalid && w_beat_last) w_next = IDLE;
      WR_REQ:      if (i_mem_req_ready) w_next = WR_DONE;
      default:     w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_wdata <= '0;
      r_be <= '0;
      r_beat <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_addr <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_be <= i_req_be;
      end
      if ((r_state == REFILL_REQ) && i_mem_req_ready) r_beat <= '0;
      else if (w_refill_we) r_beat <= r_beat + WSEL_W'(1);
    end
  end
  // WR_DONE holds stall low without a lookup so the frozen store is not replayed
  assign o_rdata = (w_lookup && !i_req_write && w_hit) ? w_rd_word : '0;
  assign o_stall = (r_state == IDLE) ? w_capture : (r_state != WR_DONE);
  assign o_mem_req_valid = (r_state == REFILL_REQ) || (r_state == WR_REQ);
  assign o_mem_req_write = r_state == WR_REQ;
  assign o_mem_req_addr = (r_state == REFILL_REQ) ? ADDR_WIDTH'(line_base(r_addr, WSEL_W)) :
                          (r_state == WR_REQ) ? {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_mem_req_wdata = (r_state == WR_REQ) ? r_wdata : '0;
  assign o_mem_req_be = (r_state == WR_REQ) ? r_be : '0;
  logic w_unused;
  assign w_unused = ^w_r_wsel;
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed scoreboard bench for the data cache
module tb_dcache;
  logic clk, rst_n;
  logic req_valid, req_write, mem_req_ready, mem_rvalid;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [3:0] req_be;
  logic [31:0] rdata, mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_be;
  logic stall, mem_req_valid, mem_req_write;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  dcache dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rdata(rdata), .o_stall(stall),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_req_write(mem_req_write), .o_mem_req_addr(mem_req_addr),
    .o_mem_req_wdata(mem_req_wdata), .o_mem_req_be(mem_req_be),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, d, input logic [3:0] be);
    push("mem_req_valid", 32'd1);
    push("mem_req_write", 32'(w));
    push("mem_req_addr", a);
    push("bus_stall", 32'd1);
    if (w) begin
      push("mem_req_wdata", d);
      push("mem_req_be", 32'(be));
    end
    @(negedge clk);
    chk(32'(mem_req_valid));
    chk(32'(mem_req_write));
    chk(mem_req_addr);
    chk(32'(stall));
    if (w) begin
      chk(mem_req_wdata);
      chk(32'(mem_req_be));
    end
  endtask

  task automatic idle_chk(input string tag);
    push({tag, "_stall"}, 32'd0);
    push({tag, "_mem_req_valid"}, 32'd0);
    @(negedge clk);
    chk(32'(stall));
    chk(32'(mem_req_valid));
  endtask

  task automatic load_miss(input logic [31:0] addr, base, input int delay);
    req_valid = 1; req_write = 0; req_addr = addr;
    push("miss_stall", 32'd1);
    @(negedge clk); chk(32'(stall));
    cyc;
    for (int i = 0; i < delay; i++) begin
      bus(1'b0, addr & ~32'hF, 32'd0, 4'd0);
      cyc;
    end
    mem_req_ready = 1;
    bus(1'b0, addr & ~32'hF, 32'd0, 4'd0);
    cyc;
    mem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1; mem_rdata = base + 32'(k);
      push("refill_stall", 32'd1);
      @(negedge clk); chk(32'(stall));
      cyc;
    end
    mem_rvalid = 0;
    push("relookup_stall", 32'd0);
    push("relookup_rdata", base + 32'(addr[3:2]));
    @(negedge clk); chk(32'(stall)); chk(rdata);
    cyc;
    req_valid = 0;
  endtask

  task automatic load_hit(input logic [31:0] addr, exp);
    req_valid = 1; req_write = 0; req_addr = addr;
    push("hit_stall", 32'd0);
    push("hit_rdata", exp);
    @(negedge clk); chk(32'(stall)); chk(rdata);
    cyc;
    req_valid = 0;
  endtask

  task automatic store(input logic [31:0] addr, d, input logic [3:0] be, input int delay);
    req_valid = 1; req_write = 1; req_addr = addr; req_wdata = d; req_be = be;
    push("store_stall", 32'd1);
    @(negedge clk); chk(32'(stall));
    cyc;
    req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    for (int i = 0; i < delay; i++) begin
      bus(1'b1, addr & ~32'h3, d, be);
      cyc;
    end
    mem_req_ready = 1;
    bus(1'b1, addr & ~32'h3, d, be);
    cyc;
    mem_req_ready = 0;
    req_wdata = d; req_be = be;
    idle_chk("wr_done");
    cyc;
    req_valid = 0; req_write = 0;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    push("rst_stall", 32'd0);
    push("rst_mem_req_valid", 32'd0);
    push("rst_mem_req_addr", 32'd0);
    push("rst_rdata", 32'd0);
    @(negedge clk);
    chk(32'(stall)); chk(32'(mem_req_valid)); chk(mem_req_addr); chk(rdata);
    cyc;
    rst_n = 1;
    idle_chk("idle");
    cyc;
    load_miss(32'h100, 32'hA0, 0);
    load_hit(32'h104, 32'hA1);
    store(32'h104, 32'h0000_FF00, 4'b0010, 0);
    load_hit(32'h104, 32'h0000_FFA1);
    store(32'h200, 32'hDEAD_BEEF, 4'hF, 0);
    load_miss(32'h200, 32'hB0, 0);
    load_miss(32'h100, 32'hC0, 0);
    load_miss(32'h500, 32'hD0, 0);
    load_hit(32'h508, 32'hD2);
    load_miss(32'h100, 32'h10, 0);
    load_miss(32'h300, 32'hE0, 5);
    store(32'h304, 32'h1234_5678, 4'b1001, 5);
    load_hit(32'h304, 32'h1200_0078);
    load_miss(32'h14C, 32'h40, 0);
    load_hit(32'h140, 32'h40);
    req_valid = 1; req_write = 0; req_addr = 32'h100; mem_req_ready = 1;
    cyc;
    cyc;
    mem_req_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'h77;
    cyc;
    cyc;
    rst_n = 0; req_valid = 0;
    idle_chk("rst_mid");
    cyc;
    rst_n = 1;
    idle_chk("stray1");
    cyc;
    idle_chk("stray2");
    cyc;
    mem_rvalid = 0;
    load_miss(32'h100, 32'hF0, 0);
    load_miss(32'h140, 32'h50, 0);
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
